// File: rtl/ccg_bist_pkg.sv
// ccg_bist_pkg: shared state encoding, MISR defaults and the MISR step function
// used by both the response reader and its reference model.
package ccg_bist_pkg;

    typedef enum logic [1:0] {IDLE, APPLY, CAPTURE, FINISH} state_t;

    localparam int          MISR_MAX = 64;
    localparam logic [19:0] DEF_POLY = 20'h00009;
    localparam logic [19:0] DEF_SEED = 20'h00000;

    // One MISR shift for a register of `width` bits (width < MISR_MAX), operands zero-extended.
    function automatic logic [MISR_MAX-1:0] misr_step(
        input logic [MISR_MAX-1:0] sig,
        input logic [MISR_MAX-1:0] poly,
        input logic [MISR_MAX-1:0] din,
        input int                  width
    );
        logic [MISR_MAX-1:0] mask;
        logic                msb;
        mask = (MISR_MAX'(1) << width) - MISR_MAX'(1);
        msb  = |(sig & (MISR_MAX'(1) << (width - 1)));
        misr_step = ((sig << 1) ^ (msb ? poly : '0) ^ din) & mask;
    endfunction

endpackage

// File: rtl/ccg_misr.sv
// ccg_misr: multiple-input signature register; clear loads SEED, enable compacts din.
module ccg_misr
    import ccg_bist_pkg::*;
#(
    parameter int               N_OUT = 20,
    parameter logic [N_OUT-1:0] POLY  = DEF_POLY,
    parameter logic [N_OUT-1:0] SEED  = DEF_SEED
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [N_OUT-1:0] din,
    output logic [N_OUT-1:0] sig
);

    logic [N_OUT-1:0] sig_q, sig_d;

    always_comb begin
        sig_d = clear  ? SEED :
                enable ? N_OUT'(misr_step(MISR_MAX'(sig_q), MISR_MAX'(POLY), MISR_MAX'(din), N_OUT)) :
                         sig_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sig_q <= SEED;
        else        sig_q <= sig_d;
    end

    assign sig = sig_q;

endmodule

// File: rtl/ccg_bist_response_reader.sv
// ccg_bist_response_reader: walks every benchmark input vector, holds each for SETTLE
// cycles, compacts the responses in a MISR and flags the signature against GOLDEN.
module ccg_bist_response_reader
    import ccg_bist_pkg::*;
#(
    parameter int               N_IN   = 4,
    parameter int               N_OUT  = 20,
    parameter logic [N_OUT-1:0] POLY   = DEF_POLY,
    parameter logic [N_OUT-1:0] SEED   = DEF_SEED,
    parameter int               SETTLE = 2,
    parameter logic [N_OUT-1:0] GOLDEN = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [N_IN-1:0]  vec_o,
    input  logic [N_OUT-1:0] resp_i,
    output logic             busy,
    output logic             done,
    output logic             sig_valid,
    output logic [N_OUT-1:0] signature,
    output logic             pass
);

    localparam logic [N_IN-1:0] VEC_LAST = '1;
    localparam logic [3:0]      CNT_LAST = 4'(SETTLE - 1);

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic            valid_q, valid_d;
    logic            misr_clear, misr_en;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        vec_d      = vec_q;
        valid_d    = valid_q;
        misr_clear = 1'b0;
        misr_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = APPLY;
                    cnt_d      = '0;
                    vec_d      = '0;
                    valid_d    = 1'b0;
                    misr_clear = 1'b1;
                end
            end
            APPLY: begin
                cnt_d = cnt_q + 4'd1;
                if (abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    vec_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                // abort wins over the capture so the partial signature is left untouched
                if (abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    vec_d   = '0;
                end else begin
                    misr_en = 1'b1;
                    if (vec_q == VEC_LAST) begin
                        state_d = FINISH;
                        valid_d = 1'b1;
                    end else begin
                        state_d = APPLY;
                        cnt_d   = '0;
                        vec_d   = vec_q + N_IN'(1);
                    end
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            vec_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            valid_q <= valid_d;
        end
    end

    ccg_misr #(
        .N_OUT (N_OUT),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (misr_clear),
        .enable (misr_en),
        .din    (resp_i),
        .sig    (signature)
    );

    assign vec_o     = vec_q;
    assign busy      = state_q != IDLE;
    assign done      = state_q == FINISH;
    assign sig_valid = valid_q;
    assign pass      = valid_q & (signature == GOLDEN);

endmodule

// File: tb/tb_ccg_bist_response_reader.sv
// tb_ccg_bist_response_reader: directed runs with a done-triggered scoreboard monitor.
module tb_ccg_bist_response_reader;
    import ccg_bist_pkg::*;

    localparam int               N_IN   = 4;
    localparam int               N_OUT  = 20;
    localparam int               SETTLE = 2;
    localparam int               RUN    = (1 << N_IN) * (SETTLE + 1);
    localparam logic [N_OUT-1:0] POLY   = 20'h00009;
    localparam logic [N_OUT-1:0] SEED   = 20'h00000;

    typedef struct {
        logic [N_OUT-1:0] sig;
        logic             pass;
        int               cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [N_IN-1:0]  vec_o;
    logic [N_OUT-1:0] resp_i;
    logic             busy, done, sig_valid, pass;
    logic [N_OUT-1:0] signature;
    int               mode = 0;
    int               cyc = 0;
    int               checks = 0;
    int               failures = 0;
    exp_t             sb[$];
    exp_t             got_e;

    ccg_bist_response_reader #(
        .N_IN   (N_IN),
        .N_OUT  (N_OUT),
        .POLY   (POLY),
        .SEED   (SEED),
        .SETTLE (SETTLE),
        .GOLDEN (20'h00000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .vec_o     (vec_o),
        .resp_i    (resp_i),
        .busy      (busy),
        .done      (done),
        .sig_valid (sig_valid),
        .signature (signature),
        .pass      (pass)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in benchmark circuits selected by mode
    function automatic logic [N_OUT-1:0] bench(input int m, input logic [N_IN-1:0] v);
        case (m)
            1:       return (v == 4'd15) ? 20'h00001 : 20'h00000;
            2:       return (v == 4'd14) ? 20'h80000 : 20'h00000;
            3:       return {16'h0000, v};
            4:       return {v, ~v, v ^ 4'h5, {v[0], v[3:1]}, v + 4'd3};
            default: return 20'h00000;
        endcase
    endfunction

    function automatic logic [N_OUT-1:0] model(input int m);
        logic [N_OUT-1:0] s = SEED;
        for (int v = 0; v < (1 << N_IN); v++)
            s = N_OUT'(misr_step(MISR_MAX'(s), MISR_MAX'(POLY), MISR_MAX'(bench(m, N_IN'(v))), N_OUT));
        return s;
    endfunction

    always_comb resp_i = bench(mode, vec_o);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 expected done=0 at cycle %0d", cyc);
            end else begin
                got_e = sb.pop_front();
                check("done_cycle", cyc, got_e.cyc);
                check("signature", signature, got_e.sig);
                check("sig_valid_at_done", sig_valid, 1);
                check("pass", pass, got_e.pass);
            end
        end
    end

    task automatic launch(input int m, output int k);
        @(negedge clk);
        mode  = m;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        k     = cyc;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 4 * RUN && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got no done expected %0d pending", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic do_run(input int m, input logic [N_OUT-1:0] exp_sig);
        int k;
        launch(m, k);
        sb.push_back('{exp_sig, exp_sig == 20'h00000, k + RUN});
        wait_drain();
    endtask

    task automatic wait_vec(input logic [N_IN-1:0] v);
        for (int i = 0; i < 2 * RUN && vec_o != v; i++) @(negedge clk);
        check("reach_vec", vec_o, v);
    endtask

    initial begin
        int k;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sig_valid", sig_valid, 0);
        check("rst_pass", pass, 0);
        check("rst_vec", vec_o, 0);
        check("rst_signature", signature, SEED);
        #20;
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk) abort = 1'b1;
        @(posedge clk) #1 abort = 1'b0;
        check("abort_idle_busy", busy, 0);

        // All-zero responses, vector stepping and start during FINISH
        launch(0, k);
        sb.push_back('{20'h00000, 1'b1, k + RUN});
        for (int j = 0; j < 16; j++) begin
            if (j > 0) repeat (SETTLE + 1) @(posedge clk);
            #1 check("vec_step", vec_o, j);
        end
        for (int i = 0; i < RUN && !done; i++) @(negedge clk);
        start = 1'b1;
        @(posedge clk) #1 start = 1'b0;
        check("start_in_finish_busy", busy, 0);
        check("sig_valid_hold", sig_valid, 1);
        check("pass_hold", pass, 1);
        wait_drain();

        do_run(1, 20'h00001);
        do_run(2, 20'h00009);
        do_run(3, 20'h008F7);
        do_run(4, model(4));

        // Abort at vector 7, then an uninterrupted rerun
        launch(3, k);
        wait_vec(4'd7);
        abort = 1'b1;
        @(posedge clk) #1 abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_vec", vec_o, 0);
        check("abort_sig_valid", sig_valid, 0);
        repeat (RUN + 4) @(negedge clk);
        do_run(3, 20'h008F7);

        // start and abort together in IDLE: start wins
        @(negedge clk);
        mode  = 3;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk) #1;
        start = 1'b0;
        abort = 1'b0;
        k     = cyc;
        sb.push_back('{20'h008F7, 1'b0, k + RUN});
        check("start_beats_abort", busy, 1);
        wait_drain();

        // Asynchronous reset mid-APPLY, then a rerun with start pulses while busy
        launch(3, k);
        wait_vec(4'd5);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_vec", vec_o, 0);
        check("arst_signature", signature, SEED);
        check("arst_sig_valid", sig_valid, 0);
        check("arst_done", done, 0);
        @(negedge clk) rst_n = 1'b1;
        launch(3, k);
        sb.push_back('{20'h008F7, 1'b0, k + RUN});
        repeat (7) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (20) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ccg_bist_response_reader.md
Name: ccg_bist_response_reader

Overview:
- Sequential tester that sits on the far end of a generated combinational benchmark (N_IN inputs, N_OUT outputs, e.g. 4-in/20-out CCG circuits).
- Drives the benchmark inputs exhaustively through every input vector and reads back its outputs.
- Compacts the responses into a MISR signature and compares the result against a golden value.
- Used by the dataset flow to fingerprint balanced and unbalanced netlist variants in simulation or on FPGA.

Parameters:
- N_IN, 4, benchmark input count; 2**N_IN vectors are applied.
- N_OUT, 20, benchmark output count and MISR width.
- POLY, 20'h00009, MISR feedback taps (bit i set = tap at bit i); width N_OUT.
- SEED, 20'h00000, MISR initial value.
- SETTLE, 2, hold cycles per vector before capture; legal range 1..15.
- GOLDEN, 20'h00000, expected final signature.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; begins a run when idle.
- abort  in  1  synchronous; ends a run without done.
- vec_o  out  N_IN  stimulus to the benchmark; bit i drives xi.
- resp_i  in  N_OUT  benchmark outputs; bit k-1 = fk.
- busy  out  1  high while a run is in progress.
- done  out  1  one-cycle pulse when the final capture completes.
- sig_valid  out  1  level; signature holds a completed result.
- signature  out  N_OUT  MISR contents.
- pass  out  1  sig_valid & (signature == GOLDEN).

Behaviour:
- Reset values (asynchronous, immediate):
  - state = IDLE
  - vec_o = 0, signature = SEED
  - busy = done = sig_valid = pass = 0
  - settle counter = 0
- IDLE:
  - start=1 moves to APPLY next cycle, with vec_o=0, signature=SEED, sig_valid=0 and the settle counter cleared.
  - abort is ignored in IDLE.
- APPLY:
  - vec_o is held stable and the settle counter increments each cycle.
  - When the counter reaches SETTLE-1, the next state is CAPTURE.
- CAPTURE (one cycle):
  - MISR update: sig <= {sig[N_OUT-2:0],1'b0} ^ (sig[N_OUT-1] ? POLY : 0) ^ resp_i.
  - If vec_o == 2**N_IN-1, go to FINISH. Otherwise vec_o increments and the state returns to APPLY with the counter cleared.
- FINISH (one cycle):
  - done=1 and sig_valid is set.
  - Next state is IDLE.
- Timing:
  - Each vector occupies exactly SETTLE+1 cycles.
  - A run takes 2**N_IN*(SETTLE+1) cycles, counted from the first APPLY cycle through the last CAPTURE.
  - done is asserted on the following cycle. For defaults this is 48 cycles, with done on cycle 49.
- busy is 1 in APPLY, CAPTURE and FINISH, and 0 otherwise.
- start while busy: ignored, no restart.
- start in the same cycle as FINISH: ignored. A new start is accepted from IDLE on the next cycle.
- abort in APPLY or CAPTURE:
  - Next state is IDLE and the CAPTURE update of that cycle is suppressed.
  - vec_o returns to 0, sig_valid stays 0 and no done is issued.
  - signature keeps its partial value but is flagged invalid.
- abort with start in the same cycle while IDLE: start wins.
- rst_n low mid-run: all state returns to reset values immediately, and no done is issued.
- vec_o wrap: the counter never wraps inside a run; the terminal vector is detected explicitly.
- resp_i is sampled only in CAPTURE. Values in other cycles are don't-care, including X.
- pass is combinational from registered values only.

Decomposition:
- Shared package ccg_bist_pkg holds:
  - the state enum (IDLE, APPLY, CAPTURE, FINISH)
  - default POLY/SEED constants
  - the misr_step function, shared with the testbench reference model.
- One sub-module is natural: ccg_misr (N_OUT, POLY, SEED; clk, rst_n, clear, enable, din, sig).
- The top contains only the FSM, the settle counter and the vector counter.

Test Plan:
- Response tied to 0 with defaults; start at cycle 0 -> vec_o steps 0..15 every 3 cycles, done once at cycle 49, signature=20'h00000, pass=1.
- resp_i=20'h00001 only when vec_o==15, all else 0 -> signature=20'h00001, pass=0 (GOLDEN=0).
- resp_i=20'h80000 at vec_o==14, 0 otherwise -> signature = shift of 20'h80000 with feedback = 20'h00009, verified against the misr_step model.
- Connect the real 4-in/20-out benchmark -> signature equals the package-model signature computed over its 16 responses; pass matches when GOLDEN is set to that value.
- abort pulsed at vector 7 -> busy drops next cycle, vec_o=0, no done, sig_valid=0; a subsequent start completes normally with the same signature as an uninterrupted run.
- rst_n low mid-APPLY at vector 5, then start again -> outputs return to reset values asynchronously; the second run produces the identical signature; start pulses while busy have no effect on timing.
